// File: rtl/engine_start_sequencer.sv
// Engine start sequencer: cranks until the engine runs or a crank window expires,
// retries after a cooldown, locks out after repeated failures, and handles stop/stall.
module engine_start_sequencer #(
  parameter int CRANK_CYCLES = 16,
  parameter int COOL_CYCLES  = 32,
  parameter int MAX_TRIES    = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       sense,
  input  logic       clear,
  output logic       starter,
  output logic       ignition,
  output logic       running,
  output logic       fault,
  output logic       stall,
  output logic [3:0] tries,
  output logic [2:0] state
);

  localparam int MAX_CYC = (CRANK_CYCLES > COOL_CYCLES) ? CRANK_CYCLES : COOL_CYCLES;
  localparam int TW      = ($clog2(MAX_CYC) < 1) ? 1 : $clog2(MAX_CYC);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CRANK     = 3'd1,
    S_COOLDOWN  = 3'd2,
    S_RUN       = 3'd3,
    S_STOP_WAIT = 3'd4,
    S_LOCKOUT   = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    tries_q, tries_d;
  logic          start_q;
  logic          stall_d;
  logic          start_edge;

  assign start_edge = start & ~start_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      tries_q <= '0;
      start_q <= 1'b0;
      stall   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      tries_q <= tries_d;
      start_q <= start;
      stall   <= stall_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    stall_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_edge && !sense && !stop) begin
          state_d = S_CRANK;
          tries_d = 4'd1;
        end
      end
      // Abort wins over a confirmed start, which wins over the crank timeout.
      S_CRANK: begin
        if (stop)
          state_d = S_IDLE;
        else if (sense)
          state_d = S_RUN;
        else if (timer_q == TW'(CRANK_CYCLES - 1))
          state_d = (tries_q == 4'(MAX_TRIES)) ? S_LOCKOUT : S_COOLDOWN;
      end
      S_COOLDOWN: begin
        if (stop)
          state_d = S_IDLE;
        else if (timer_q == TW'(COOL_CYCLES - 1)) begin
          state_d = S_CRANK;
          tries_d = tries_q + 4'd1;
        end
      end
      S_RUN: begin
        if (stop)
          state_d = S_STOP_WAIT;
        else if (!sense) begin
          state_d = S_IDLE;
          stall_d = 1'b1;
        end
      end
      S_STOP_WAIT: begin
        if (!sense)
          state_d = S_IDLE;
      end
      S_LOCKOUT: begin
        if (clear) begin
          state_d = S_IDLE;
          tries_d = 4'd0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // The timer only counts inside the timed states and restarts on every transition.
    if (state_d != state_q)
      timer_d = '0;
    else if (state_q == S_CRANK || state_q == S_COOLDOWN)
      timer_d = timer_q + TW'(1);
    else
      timer_d = '0;
  end

  always_comb begin
    starter  = 1'b0;
    ignition = 1'b0;
    running  = 1'b0;
    fault    = 1'b0;
    case (state_q)
      S_CRANK:   begin starter = 1'b1; ignition = 1'b1; end
      S_RUN:     begin ignition = 1'b1; running = 1'b1; end
      S_LOCKOUT: fault = 1'b1;
      default:   ;
    endcase
  end

  assign tries = tries_q;
  assign state = state_q;

endmodule

// File: tb/tb_engine_start_sequencer.sv
// Bench for engine_start_sequencer: directed scenarios plus random stimulus,
// every cycle compared against a phase/age reference model.
module tb_engine_start_sequencer;

  localparam int CRANK = 4;
  localparam int COOL  = 3;
  localparam int MAXT  = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0, stop = 1'b0, sense = 1'b0, clear = 1'b0;
  logic       starter, ignition, running, fault, stall;
  logic [3:0] tries;
  logic [2:0] state;

  int n_vec = 0;
  int n_err = 0;

  // reference model
  string m_phase = "IDLE";
  int    m_age   = 0;
  int    m_tries = 0;
  bit    m_prev  = 1'b0;
  bit    m_stall = 1'b0;

  engine_start_sequencer #(
    .CRANK_CYCLES(CRANK), .COOL_CYCLES(COOL), .MAX_TRIES(MAXT)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .stop(stop), .sense(sense),
    .clear(clear), .starter(starter), .ignition(ignition), .running(running),
    .fault(fault), .stall(stall), .tries(tries), .state(state)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic enter(input string ph);
    m_phase = ph;
    m_age   = 0;
  endtask

  task automatic model_step(input bit r, input bit st, input bit sp, input bit se, input bit cl);
    bit edge_seen;
    if (r) begin
      enter("IDLE");
      m_tries = 0;
      m_prev  = 1'b0;
      m_stall = 1'b0;
      return;
    end
    edge_seen = st && !m_prev;
    m_prev    = st;
    m_stall   = 1'b0;
    case (m_phase)
      "IDLE":
        if (edge_seen && !se && !sp) begin enter("CRANK"); m_tries = 1; end
      "CRANK":
        if (sp) enter("IDLE");
        else if (se) enter("RUN");
        else if (m_age == CRANK - 1) enter(m_tries == MAXT ? "LOCKOUT" : "COOLDOWN");
        else m_age++;
      "COOLDOWN":
        if (sp) enter("IDLE");
        else if (m_age == COOL - 1) begin enter("CRANK"); m_tries++; end
        else m_age++;
      "RUN":
        if (sp) enter("STOP_WAIT");
        else if (!se) begin enter("IDLE"); m_stall = 1'b1; end
      "STOP_WAIT":
        if (!se) enter("IDLE");
      "LOCKOUT":
        if (cl) begin enter("IDLE"); m_tries = 0; end
      default: enter("IDLE");
    endcase
  endtask

  // Called at a negedge: drive inputs, let one posedge pass, then compare at the next negedge.
  task automatic cycle(input bit r, input bit st, input bit sp, input bit se, input bit cl);
    reset = r; start = st; stop = sp; sense = se; clear = cl;
    @(posedge clock);
    model_step(r, st, sp, se, cl);
    @(negedge clock);
    check("starter",  {7'd0, starter},  {7'd0, m_phase == "CRANK"});
    check("ignition", {7'd0, ignition}, {7'd0, m_phase == "CRANK" || m_phase == "RUN"});
    check("running",  {7'd0, running},  {7'd0, m_phase == "RUN"});
    check("fault",    {7'd0, fault},    {7'd0, m_phase == "LOCKOUT"});
    check("stall",    {7'd0, stall},    {7'd0, m_stall});
    check("tries",    {4'd0, tries},    8'(m_tries));
    check("state_legal", {7'd0, state <= 3'd5}, 8'd1);
  endtask

  initial begin
    bit st, sp, se, cl, r;
    @(negedge clock);
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("rst_tries", {4'd0, tries}, 8'd0);
    check("rst_ignition", {7'd0, ignition}, 8'd0);

    // normal start
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    check("t1_starter", {7'd0, starter}, 8'd1);
    cycle(0, 1, 0, 1, 0);
    check("t1_running", {7'd0, running}, 8'd1);
    check("t1_starter_off", {7'd0, starter}, 8'd0);
    check("t1_tries", {4'd0, tries}, 8'd1);

    // stall from RUN
    cycle(0, 0, 0, 0, 0);
    check("t4_stall", {7'd0, stall}, 8'd1);
    check("t4_running", {7'd0, running}, 8'd0);
    cycle(0, 0, 0, 0, 0);
    check("t4_stall_once", {7'd0, stall}, 8'd0);

    // retry then lockout
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 11; i++) cycle(0, 0, 0, 0, 0);
    check("t2_fault", {7'd0, fault}, 8'd1);
    check("t2_tries", {4'd0, tries}, 8'd2);
    cycle(0, 1, 1, 1, 0);
    check("t2_locked", {7'd0, fault}, 8'd1);
    cycle(0, 0, 0, 0, 1);
    check("t2_clear_tries", {4'd0, tries}, 8'd0);
    check("t2_clear_fault", {7'd0, fault}, 8'd0);

    // stop while running
    cycle(0, 1, 0, 0, 0);
    cycle(0, 0, 0, 1, 0);
    cycle(0, 0, 1, 1, 0);
    check("t3_ign_off", {7'd0, ignition}, 8'd0);
    for (int i = 0; i < 5; i++) cycle(0, 1, 0, 1, 0);
    cycle(0, 0, 0, 0, 0);
    check("t3_idle", {7'd0, running | starter}, 8'd0);

    // held start through a stop abort, then stop+sense together
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 0, 0);
    check("t5_no_recrank", {7'd0, starter}, 8'd0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 1, 1, 0);
    check("t5_stop_beats_sense", {7'd0, running}, 8'd0);

    // reset mid-crank
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0);
    check("t6_starter", {7'd0, starter}, 8'd0);
    check("t6_tries", {4'd0, tries}, 8'd0);
    cycle(0, 0, 0, 0, 0);

    // random stimulus
    se = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      st = ($urandom_range(0, 9) < 3);
      sp = ($urandom_range(0, 19) == 0);
      cl = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 99) < 15) se = ~se;
      cycle(r, st, sp, se, cl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
